// File: rtl/vga_sink.sv
// Receive-side VGA timing decoder: measures line/frame timing, locks, recovers sx/sy/de.
// Optional per-frame pixel checksum is built when VGA_SINK_CKSUM_EN is defined.
module vga_sink #(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_BP        = 33,
   parameter bit          SYNC_POL    = 1'b0,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        clk_25MHz,
   input  logic        btn_rst_n,
   input  logic        vga_hsync,
   input  logic        vga_vsync,
   input  logic [7:0]  vga_r,
   input  logic [7:0]  vga_g,
   input  logic [7:0]  vga_b,
   output logic        locked,
   output logic        de,
   output logic [15:0] sx,
   output logic [15:0] sy,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic [15:0] h_period,
   output logic [15:0] v_lines,
   output logic        frame_done,
   output logic [31:0] frame_sum
);

   typedef enum logic [1:0] {StSearch, StMeasure, StLocking, StLocked} state_t;

   localparam logic [15:0] HBEG = 16'(H_BP);
   localparam logic [15:0] HEND = 16'(H_BP + H_RES);
   localparam logic [15:0] VBEG = 16'(V_BP);
   localparam logic [15:0] VEND = 16'(V_BP + V_RES);

   state_t      r_state, w_state_next;
   logic        r_hs_act, r_vs_act, r_hs_act_d, r_vs_act_d;
   logic [7:0]  r_r1, r_g1, r_b1;
   logic [15:0] r_hcnt, r_vcnt, r_ref_h, r_ref_v, r_sx, r_sy;
   logic [3:0]  r_good, w_good_next, w_good_inc;
   logic        w_h_deas, w_v_deas, w_v_as, w_mismatch, w_ref_load, w_de, w_frame_end;
   logic [15:0] w_hcnt_p1, w_vcnt_p1, w_sx, w_sy;

   // Sync levels are normalised to "active" so the rest of the logic is polarity-free.
   always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         r_hs_act   <= 1'b0;
         r_vs_act   <= 1'b0;
         r_hs_act_d <= 1'b0;
         r_vs_act_d <= 1'b0;
         r_r1       <= '0;
         r_g1       <= '0;
         r_b1       <= '0;
         pix_r      <= '0;
         pix_g      <= '0;
         pix_b      <= '0;
      end else begin
         r_hs_act   <= (vga_hsync == SYNC_POL);
         r_vs_act   <= (vga_vsync == SYNC_POL);
         r_hs_act_d <= r_hs_act;
         r_vs_act_d <= r_vs_act;
         r_r1       <= vga_r;
         r_g1       <= vga_g;
         r_b1       <= vga_b;
         pix_r      <= r_r1;
         pix_g      <= r_g1;
         pix_b      <= r_b1;
      end
   end

   assign w_h_deas  = r_hs_act_d & ~r_hs_act;
   assign w_v_deas  = r_vs_act_d & ~r_vs_act;
   assign w_v_as    = ~r_vs_act_d & r_vs_act;
   assign w_hcnt_p1 = r_hcnt + 16'd1;
   assign w_vcnt_p1 = r_vcnt + 16'd1;
   assign w_good_inc = r_good + 4'd1;

   assign w_mismatch = (w_h_deas && (w_hcnt_p1 != r_ref_h)) ||
                       (w_v_deas && (w_vcnt_p1 != r_ref_v)) ||
                       (r_hcnt == 16'hFFFF);

   always_comb begin
      w_state_next = r_state;
      w_good_next  = r_good;
      w_ref_load   = 1'b0;
      unique case (r_state)
         StSearch:  if (w_v_deas) w_state_next = StMeasure;
         StMeasure: begin
            if (w_v_deas) begin
               w_state_next = StLocking;
               w_ref_load   = 1'b1;
               w_good_next  = '0;
            end
         end
         StLocking: begin
            if (w_mismatch) begin
               w_state_next = StSearch;
            end else if (w_v_deas) begin
               w_good_next = w_good_inc;
               if (32'(w_good_inc) == LOCK_FRAMES) w_state_next = StLocked;
            end
         end
         StLocked:  if (w_mismatch) w_state_next = StSearch;
         default:   w_state_next = StSearch;
      endcase
   end

   always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         r_state  <= StSearch;
         r_good   <= '0;
         r_ref_h  <= '0;
         r_ref_v  <= '0;
         r_hcnt   <= '0;
         r_vcnt   <= '0;
         h_period <= '0;
         v_lines  <= '0;
         r_sx     <= '0;
         r_sy     <= '0;
         frame_done <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_good  <= w_good_next;
         if (w_ref_load) begin
            r_ref_h <= h_period;
            r_ref_v <= w_vcnt_p1;
         end
         if (w_h_deas) r_hcnt <= '0;
         else if (r_hcnt != 16'hFFFF) r_hcnt <= w_hcnt_p1;
         if (w_v_deas) r_vcnt <= '0;
         else if (w_h_deas) r_vcnt <= w_vcnt_p1;
         if (w_h_deas) h_period <= w_hcnt_p1;
         if (w_v_deas) v_lines <= w_vcnt_p1;
         if (w_de) begin
            r_sx <= w_sx;
            r_sy <= w_sy;
         end
         frame_done <= w_frame_end;
      end
   end

   // Counters track the pixel currently held in pix_*, so de/sx/sy line up with it.
   assign locked = (r_state == StLocked);
   assign w_de = locked && (r_hcnt >= HBEG) && (r_hcnt < HEND) &&
                 (r_vcnt >= VBEG) && (r_vcnt < VEND);
   assign de   = w_de;
   assign w_sx = r_hcnt - HBEG;
   assign w_sy = r_vcnt - VBEG;
   assign sx   = w_de ? w_sx : r_sx;
   assign sy   = w_de ? w_sy : r_sy;
   assign w_frame_end = locked && w_v_as && !w_mismatch;

`ifdef VGA_SINK_CKSUM_EN
   logic [31:0] r_acc;

   always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         r_acc     <= '0;
         frame_sum <= '0;
      end else begin
         if (w_v_deas) r_acc <= '0;
         else if (w_de) r_acc <= r_acc + {24'd0, pix_r} + {24'd0, pix_g} + {24'd0, pix_b};
         if (w_frame_end) frame_sum <= r_acc;
      end
   end
`else
   assign frame_sum = '0;
`endif

endmodule
